// File: rtl/game_pkg.sv
// Shared encodings for the reel game: round-controller states and the
// 5-bit indicator codes understood by the display decoder.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SPIN      = 3'd1,
        ST_EVAL      = 3'd2,
        ST_SHOW_WIN  = 3'd3,
        ST_SHOW_LOSE = 3'd4
    } state_t;

    localparam logic [4:0] MSG_G = 5'h10;
    localparam logic [4:0] MSG_O = 5'h11;
    localparam logic [4:0] MSG_D = 5'h12;
    localparam logic [4:0] MSG_L = 5'h13;
    localparam logic [4:0] MSG_S = 5'h14;
    localparam logic [4:0] MSG_E = 5'h15;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/reel_round_sequencer_key_edge_detect.sv
// Rising-edge detector for level keys: a key held down yields one press.
module key_edge_detect #(
    parameter int w = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [w-1:0] key,
    output logic [w-1:0] press
);

    logic [w-1:0] key_q;

    always_ff @(posedge clk) begin
        if (reset) key_q <= '0;
        else       key_q <= key;
    end

    assign press = key & ~key_q;

endmodule

// File: rtl/reel_round_sequencer.sv
// Round controller: starts reels on a press, stops them from key presses,
// scores the frozen letters and holds GOOD/LOSE on the display.
module reel_round_sequencer
    import game_pkg::*;
#(
    parameter int letter_width  = 4,
    parameter int hold_cycles   = 255,
    parameter bit enforce_order = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              key,
    input  logic [letter_width-1:0] letter0,
    input  logic [letter_width-1:0] letter1,
    input  logic [letter_width-1:0] letter2,
    input  logic [letter_width-1:0] letter3,
    output logic [3:0]              stop_flag,
    output logic                    end_flag,
    output logic [4:0]              message0,
    output logic [4:0]              message1,
    output logic [4:0]              message2,
    output logic [4:0]              message3,
    output logic [3:0]              score,
    output logic [2:0]              state_out
);

    localparam int CW = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(hold_cycles - 1);

    state_t            state_q, state_d;
    logic [3:0]        stop_q, stop_d;
    logic              end_q, end_d;
    logic [3:0][4:0]   msg_q, msg_d;
    logic [3:0]        score_q, score_d;
    logic [1:0]        idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        press;
    logic              win;

    key_edge_detect #(.w(4)) u_edge (
        .clk   (clk),
        .reset (reset),
        .key   (key),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stop_q  <= '0;
            end_q   <= 1'b0;
            msg_q   <= '0;
            score_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            end_q   <= end_d;
            msg_q   <= msg_d;
            score_q <= score_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        end_d   = end_q;
        msg_d   = msg_q;
        score_d = score_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        win     = (letter0 == letter1) && (letter1 == letter2) && (letter2 == letter3);

        case (state_q)
            ST_IDLE: begin
                if (|press) begin
                    state_d = ST_SPIN;
                    stop_d  = 4'hF;
                    idx_d   = '0;
                end
            end
            ST_SPIN: begin
                // The last reel stops on one edge; evaluation starts on the next.
                if (stop_q == 4'h0) begin
                    state_d = ST_EVAL;
                end else if (enforce_order) begin
                    if (press[idx_q]) begin
                        stop_d[idx_q] = 1'b0;
                        idx_d         = idx_q + 2'd1;
                    end
                end else begin
                    stop_d = stop_q & ~press;
                end
            end
            ST_EVAL: begin
                end_d = 1'b1;
                cnt_d = '0;
                if (win) begin
                    state_d = ST_SHOW_WIN;
                    score_d = sat_inc4(score_q);
                    msg_d   = {MSG_D, MSG_O, MSG_O, MSG_G};
                end else begin
                    state_d = ST_SHOW_LOSE;
                    msg_d   = {MSG_E, MSG_S, MSG_O, MSG_L};
                end
            end
            ST_SHOW_WIN, ST_SHOW_LOSE: begin
                if (cnt_q == HOLD_LAST) begin
                    end_d   = 1'b0;
                    msg_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stop_flag = stop_q;
    assign end_flag  = end_q;
    assign message0  = msg_q[0];
    assign message1  = msg_q[1];
    assign message2  = msg_q[2];
    assign message3  = msg_q[3];
    assign score     = score_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_reel_round_sequencer.sv
// Bench for reel_round_sequencer: an in-order instance and an any-order
// instance, checked against a score/outcome model derived from the game rules.
module tb_reel_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keyA, keyB;
    logic [3:0] lA0, lA1, lA2, lA3, lB0, lB1, lB2, lB3;
    logic [3:0] stopA, stopB, scoreA, scoreB;
    logic       endA, endB;
    logic [4:0] mA0, mA1, mA2, mA3, mB0, mB1, mB2, mB3;
    logic [2:0] stA, stB;

    int vec  = 0;
    int errs = 0;
    int sc   = 0;   // model score of instance A

    always #5 clk = ~clk;

    reel_round_sequencer #(.letter_width(4), .hold_cycles(8), .enforce_order(1'b1)) dut (
        .clk(clk), .reset(reset), .key(keyA),
        .letter0(lA0), .letter1(lA1), .letter2(lA2), .letter3(lA3),
        .stop_flag(stopA), .end_flag(endA),
        .message0(mA0), .message1(mA1), .message2(mA2), .message3(mA3),
        .score(scoreA), .state_out(stA)
    );

    reel_round_sequencer #(.letter_width(4), .hold_cycles(8), .enforce_order(1'b0)) dut_any (
        .clk(clk), .reset(reset), .key(keyB),
        .letter0(lB0), .letter1(lB1), .letter2(lB2), .letter3(lB3),
        .stop_flag(stopB), .end_flag(endB),
        .message0(mB0), .message1(mB1), .message2(mB2), .message3(mB3),
        .score(scoreB), .state_out(stB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pressA(input logic [3:0] k);
        keyA = k; tick();
        keyA = 4'h0; tick();
    endtask

    task automatic pressB(input logic [3:0] k);
        keyB = k; tick();
        keyB = 4'h0; tick();
    endtask

    task automatic wait_idle_A();
        int n;
        n = 0;
        while (stA !== 3'd0 && n < 60) begin n++; tick(); end
        vec++;
        if (stA !== 3'd0) begin
            errs++; $display("FAIL wait_idle_A timeout state=%0d", stA);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; keyA = 4'h0; keyB = 4'h0;
        tick(); tick();
        vec++;
        if ({stA, stopA, endA, scoreA, mA0, mA1, mA2, mA3} !== '0) begin
            errs++; $display("FAIL reset_A st=%0d stop=%b end=%b score=%0d exp all zero", stA, stopA, endA, scoreA);
        end
        vec++;
        if ({stB, stopB, endB, scoreB} !== '0) begin
            errs++; $display("FAIL reset_B st=%0d stop=%b end=%b score=%0d exp all zero", stB, stopB, endB, scoreB);
        end
        reset = 1'b0;
        tick();
    endtask

    // One full in-order round on instance A; outcome comes from the letter rule.
    task automatic test_round(input logic [3:0] l0, l1, l2, l3);
        logic           win;
        logic [3:0]     exp_stop;
        logic [19:0]    exp_msg;
        int             n;
        lA0 = l0; lA1 = l1; lA2 = l2; lA3 = l3;
        win = (l0 == l1) && (l1 == l2) && (l2 == l3);
        pressA(4'(1) << $urandom_range(0, 3));
        vec++;
        if (stA !== 3'd1 || stopA !== 4'hF) begin
            errs++; $display("FAIL round_start st=%0d stop=%b exp st=1 stop=1111", stA, stopA);
        end
        for (int i = 0; i < 4; i++) begin
            pressA(4'(1) << i);
            exp_stop = 4'hF << (i + 1);
            if (i < 3) begin
                vec++;
                if (stopA !== exp_stop) begin
                    errs++; $display("FAIL round_stop%0d stop=%b exp %b", i, stopA, exp_stop);
                end
            end
        end
        vec++;
        if (stA !== 3'd2 || stopA !== 4'h0) begin
            errs++; $display("FAIL round_eval st=%0d stop=%b exp st=2 stop=0000", stA, stopA);
        end
        tick();
        if (win) sc = (sc == 15) ? 15 : sc + 1;
        exp_msg = win ? {5'h10, 5'h11, 5'h11, 5'h12} : {5'h13, 5'h11, 5'h14, 5'h15};
        vec++;
        if (stA !== (win ? 3'd3 : 3'd4) || scoreA !== 4'(sc) || endA !== 1'b1) begin
            errs++; $display("FAIL round_result st=%0d score=%0d end=%b exp st=%0d score=%0d end=1",
                             stA, scoreA, endA, win ? 3 : 4, sc);
        end
        vec++;
        if ({mA0, mA1, mA2, mA3} !== exp_msg) begin
            errs++; $display("FAIL round_msg got %h %h %h %h exp %h", mA0, mA1, mA2, mA3, exp_msg);
        end
        n = 0;
        while (endA === 1'b1 && n < 40) begin n++; tick(); end
        vec++;
        if (n != 8) begin
            errs++; $display("FAIL round_hold end_flag cycles=%0d exp 8", n);
        end
        vec++;
        if (stA !== 3'd0 || {mA0, mA1, mA2, mA3} !== 20'h0 || scoreA !== 4'(sc)) begin
            errs++; $display("FAIL round_idle st=%0d msg=%h %h %h %h score=%0d exp st=0 msg=0 score=%0d",
                             stA, mA0, mA1, mA2, mA3, scoreA, sc);
        end
    endtask

    task automatic test_order_enforce();
        lA0 = 4'h5; lA1 = 4'h5; lA2 = 4'h5; lA3 = 4'h5;
        pressA(4'b0001);
        pressA(4'b0100);
        vec++;
        if (stopA !== 4'b1111) begin
            errs++; $display("FAIL order_out_of_turn stop=%b exp 1111", stopA);
        end
        pressA(4'b0011);
        vec++;
        if (stopA !== 4'b1110) begin
            errs++; $display("FAIL order_simultaneous stop=%b exp 1110", stopA);
        end
        pressA(4'b0010);
        vec++;
        if (stopA !== 4'b1100) begin
            errs++; $display("FAIL order_next_idx stop=%b exp 1100", stopA);
        end
        pressA(4'b0010);
        vec++;
        if (stopA !== 4'b1100) begin
            errs++; $display("FAIL order_repress stop=%b exp 1100", stopA);
        end
        pressA(4'b0100);
        pressA(4'b1000);
        wait_idle_A();
        sc = (sc == 15) ? 15 : sc + 1;
        vec++;
        if (scoreA !== 4'(sc)) begin
            errs++; $display("FAIL order_score score=%0d exp %0d", scoreA, sc);
        end
    endtask

    task automatic test_any_order();
        lB0 = 4'h9; lB1 = 4'h9; lB2 = 4'h9; lB3 = 4'h9;
        pressB(4'b0100);
        vec++;
        if (stB !== 3'd1 || stopB !== 4'b1111) begin
            errs++; $display("FAIL any_start st=%0d stop=%b exp st=1 stop=1111", stB, stopB);
        end
        keyB = 4'b1010; tick();
        vec++;
        if (stopB !== 4'b0101) begin
            errs++; $display("FAIL any_simultaneous stop=%b exp 0101", stopB);
        end
        keyB = 4'h0; tick();
        pressB(4'b1010);
        vec++;
        if (stopB !== 4'b0101) begin
            errs++; $display("FAIL any_stopped_ignored stop=%b exp 0101", stopB);
        end
        pressB(4'b0101);
        vec++;
        if (stB !== 3'd2 || stopB !== 4'h0) begin
            errs++; $display("FAIL any_eval st=%0d stop=%b exp st=2 stop=0000", stB, stopB);
        end
        tick();
        vec++;
        if (stB !== 3'd3 || scoreB !== 4'd1 || mB0 !== 5'h10 || endB !== 1'b1) begin
            errs++; $display("FAIL any_result st=%0d score=%0d msg0=%h end=%b exp 3 1 10 1", stB, scoreB, mB0, endB);
        end
    endtask

    task automatic test_held_key();
        lA0 = 4'h1; lA1 = 4'h2; lA2 = 4'h3; lA3 = 4'h4;
        keyA = 4'b0001;
        repeat (20) tick();
        vec++;
        if (stA !== 3'd1 || stopA !== 4'b1111) begin
            errs++; $display("FAIL held_single_press st=%0d stop=%b exp st=1 stop=1111", stA, stopA);
        end
        keyA = 4'b0000; tick();
        keyA = 4'b0001; tick();
        keyA = 4'b0011; tick();
        keyA = 4'b0001; tick();
        keyA = 4'b0101; tick();
        keyA = 4'b0001; tick();
        keyA = 4'b1001; tick();
        keyA = 4'b0001; tick();
        vec++;
        if (stA !== 3'd2) begin
            errs++; $display("FAIL held_eval st=%0d exp 2", stA);
        end
        wait_idle_A();
        repeat (5) tick();
        vec++;
        if (stA !== 3'd0) begin
            errs++; $display("FAIL held_no_restart st=%0d exp 0", stA);
        end
        keyA = 4'b0000; tick();
        keyA = 4'b0001; tick();
        vec++;
        if (stA !== 3'd1 || stopA !== 4'b1111) begin
            errs++; $display("FAIL held_repress st=%0d stop=%b exp st=1 stop=1111", stA, stopA);
        end
        keyA = 4'b0000; tick();
        for (int i = 0; i < 4; i++) pressA(4'(1) << i);
        wait_idle_A();
        vec++;
        if (scoreA !== 4'(sc)) begin
            errs++; $display("FAIL held_score score=%0d exp %0d", scoreA, sc);
        end
    endtask

    task automatic test_random_rounds();
        logic [3:0] l [4];
        for (int r = 0; r < 8; r++) begin
            l[0] = 4'($urandom_range(0, 15));
            for (int j = 1; j < 4; j++)
                l[j] = ($urandom_range(0, 1) == 1) ? l[0] : 4'($urandom_range(0, 15));
            test_round(l[0], l[1], l[2], l[3]);
        end
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 17; r++) test_round(4'h5, 4'h5, 4'h5, 4'h5);
        vec++;
        if (scoreA !== 4'd15) begin
            errs++; $display("FAIL saturation score=%0d exp 15", scoreA);
        end
    endtask

    task automatic test_reset_mid();
        pressA(4'b0001);
        pressA(4'b0001);
        pressA(4'b0010);
        vec++;
        if (stopA !== 4'b1100) begin
            errs++; $display("FAIL midreset_pre stop=%b exp 1100", stopA);
        end
        reset = 1'b1; tick();
        vec++;
        if (stopA !== 4'h0 || stA !== 3'd0 || scoreA !== 4'd0 || endA !== 1'b0) begin
            errs++; $display("FAIL midreset stop=%b st=%0d score=%0d end=%b exp 0000 0 0 0", stopA, stA, scoreA, endA);
        end
        reset = 1'b0; sc = 0;
        tick();
    endtask

    initial begin
        keyA = 4'h0; keyB = 4'h0; reset = 1'b1;
        lA0 = 4'h5; lA1 = 4'h5; lA2 = 4'h5; lA3 = 4'h5;
        lB0 = 4'h0; lB1 = 4'h0; lB2 = 4'h0; lB3 = 4'h0;
        test_reset();
        test_round(4'h5, 4'h5, 4'h5, 4'h5);
        test_round(4'h3, 4'h3, 4'h3, 4'h7);
        test_order_enforce();
        test_any_order();
        test_held_key();
        test_random_rounds();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/reel_round_sequencer.md
Name: reel_round_sequencer

Overview:
Round controller for the four-reel 7-segment game. Starts a round on a button press, stops reels one by one from debounced key presses, and compares the frozen letters once all reels have stopped. It then shows GOOD/LOSE for a fixed hold time and keeps a saturating win score. It sits between the key debouncer and the letter-counter/display datapath: stop_flag gates the per-reel letter strobes, and end_flag/messageN select the display source.

Parameters:
letter_width, 4, width of each reel letter input
hold_cycles, 255, number of cycles end_flag/message stay asserted after evaluation (min 2)
enforce_order, 1, 1 = reels must be stopped in order 0,1,2,3; 0 = any order

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key  in  4  debounced keys, level, 1 = pressed
letter0  in  letter_width  current value of reel 0 counter
letter1  in  letter_width  reel 1
letter2  in  letter_width  reel 2
letter3  in  letter_width  reel 3
stop_flag  out  4  bit i = 1 while reel i spins (ANDed with letter strobe externally)
end_flag  out  1  1 while result message is displayed
message0  out  5  display code for indicator 0 (valid when end_flag = 1)
message1  out  5  indicator 1
message2  out  5  indicator 2
message3  out  5  indicator 3
score  out  4  win count, saturates at 15
state_out  out  3  current state encoding, for debug and bench

Behaviour:
- All outputs registered. Reset values: stop_flag = 0000, end_flag = 0, message0..3 = 0, score = 0, state = IDLE, next_idx = 0, hold counter = 0, key_q = 0.
- Edge detect: press[i] = key[i] & ~key_q[i]; key_q <= key every cycle. A held key yields exactly one press.
- States (state_out): IDLE = 0, SPIN = 1, EVAL = 2, SHOW_WIN = 3, SHOW_LOSE = 4. Unused codes go to IDLE on the next cycle.
- IDLE: any press -> SPIN. stop_flag = 1111 starting the cycle after the press cycle. next_idx <= 0.
- SPIN, enforce_order = 1: only press[next_idx] is accepted; it clears stop_flag[next_idx] on the next edge and increments next_idx. Other presses are ignored, including simultaneous ones.
- SPIN, enforce_order = 0: every press[i] with stop_flag[i] = 1 clears bit i on the next edge. Simultaneous presses stop all pressed reels in the same cycle. Presses on already-stopped reels are ignored.
- SPIN -> EVAL on the cycle after stop_flag becomes 0000.
- EVAL (exactly 1 cycle): letters are frozen at this point, so letter0..3 are sampled directly. win = all four equal.
  - Win: score <= score + 1, saturating at 15. Next state SHOW_WIN, messages G,O,O,D = 10h,11h,11h,12h.
  - Otherwise: next state SHOW_LOSE, messages L,O,S,E = 13h,11h,14h,15h.
  - end_flag <= 1 and hold counter <= 0 on the same edge.
- SHOW_*: hold counter increments each cycle. When it equals hold_cycles-1: end_flag <= 0, message0..3 <= 0, state <= IDLE. end_flag is therefore high for exactly hold_cycles cycles. All presses are ignored. score is held.
- Reset at any point, mid-round or mid-show: all registers return to reset values on that edge, and score clears.
- Key held across the return to IDLE produces no press. A new round requires release and re-press.

Decomposition:
- Shared package game_pkg:
  - State encodings IDLE..SHOW_LOSE.
  - Message codes MSG_G = 10h, MSG_O = 11h, MSG_D = 12h, MSG_L = 13h, MSG_S = 14h, MSG_E = 15h.
  - These codes match the display decoder table.
- One sub-module, key_edge_detect: parameter w, inputs clk/reset/key, output press (w bits), registered key_q.
- Hold counter width = $clog2(hold_cycles).

Test Plan:
- Setup: enforce_order = 1, hold_cycles = 8, all letters = 5h.
  - Press key0 (IDLE) -> state 1, stop_flag = 1111 next cycle.
  - Press keys 0,1,2,3 in order -> stop_flag 1110, 1100, 1000, 0000, then EVAL.
  - Result: state 3, end_flag = 1 for exactly 8 cycles, messages 10h/11h/11h/12h, score = 1, then IDLE with messages 0.
- Letters 3h,3h,3h,7h, full round -> state 4, messages 13h/11h/14h/15h, score unchanged, end_flag 8 cycles.
- enforce_order = 1, SPIN with next_idx = 0: press key2, then key0+key1 together -> key2 ignored; only stop_flag[0] clears (1110), next_idx = 1.
- enforce_order = 0: press key3 and key1 simultaneously -> stop_flag 1111 -> 0101 in one edge; then key0+key2 -> 0000 -> EVAL.
- Hold key1 high for 20 cycles from IDLE -> one press only. After the round ends with key still high -> stays IDLE until release and re-press.
- 16 winning rounds -> score saturates at 15. Assert reset during SPIN (stop_flag 1100) -> next cycle stop_flag = 0000, state 0, score 0, end_flag 0.
